dynamic_branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor. It combines an 8-entry tagged branch history table (BHT) of 2-bit saturating counters with a parallel branch target buffer (BTB). It sits directly upstream of the fetch PC mux and supplies `prediction` and `predicted_target` for the current PC in the same cycle. Decode resolves branches and writes the tables back through `wen_BHT`/`wen_BTB`, and the block keeps saturating branch and misprediction statistics for the bench.

---
 rtl/branch_pred_pkg.sv | 54 +++++
 rtl/predictor_table.sv | 51 +++++
 rtl/dynamic_branch_predictor.sv | 131 +++++++++++++
 tb/tb_dynamic_branch_predictor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// ----------------------------------------------------------------------------
// branch_pred_pkg
// Shared types and helpers for the fetch-stage dynamic branch predictor.
//   ctr_t       : 2-bit saturating direction counter encoding
//   CTR_RESET   : counter value used for reset and for idle entries
//   bp_entry_t  : one predictor table entry (valid, tag, counter, target)
//   sat_update  : next value of a saturating counter given a resolved direction
// ----------------------------------------------------------------------------
package branch_pred_pkg;

    localparam int PC_W = 16;

    // Entry tags are stored at the widest width any legal IDX_W can produce
    // (IDX_W >= 1 gives at most 15 tag bits). Narrower tags are zero-extended,
    // so the entry struct does not depend on the predictor parameters.
    localparam int TAG_MAX_W = PC_W - 1;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WEAK_NT;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        ctr_t                 ctr;
        logic [PC_W-1:0]      target;
    } bp_entry_t;

    localparam bp_entry_t ENTRY_RESET = '{
        valid  : 1'b0,
        tag    : '0,
        ctr    : CTR_RESET,
        target : '0
    };

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        case (ctr)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/predictor_table.sv
// ----------------------------------------------------------------------------
// predictor_table
// Direct-mapped flop array of bp_entry_t.
//   clk, rst      : clock, asynchronous active-high reset (clears every entry)
//   rd_idx/rd_data: combinational lookup port for the fetch PC
//   wr_idx/wr_old : combinational read of the entry about to be written, used
//                   by the parent for the tag compare and counter update
//   wr_en/wr_data : synchronous write port, applied on the rising edge
// Reads always return the pre-edge contents, so a same-cycle read and write
// of one index yields the old entry.
// ----------------------------------------------------------------------------
module predictor_table
    import branch_pred_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bp_entry_t        rd_data,
    input  logic [IDX_W-1:0] wr_idx,
    output bp_entry_t        wr_old,
    input  logic             wr_en,
    input  bp_entry_t        wr_data
);

    bp_entry_t mem_q [NUM_ENTRIES];
    bp_entry_t mem_d [NUM_ENTRIES];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= ENTRY_RESET;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign wr_old  = mem_q[wr_idx];

endmodule

// File: rtl/dynamic_branch_predictor.sv
// ----------------------------------------------------------------------------
// dynamic_branch_predictor
// Fetch-stage predictor: tagged 2-bit-counter BHT with a parallel BTB, plus
// saturating branch / misprediction statistics.
//   clk, rst            : clock, asynchronous active-high reset
//   PC_curr             : fetch PC, looked up combinationally
//   prediction          : predict taken for PC_curr (hit and counter MSB set)
//   predicted_target    : BTB target for PC_curr, zero on a miss
//   IF_ID_PC_curr       : PC of the branch resolved in decode
//   IF_ID_prediction    : direction that was predicted for that branch
//   wen_BHT / wen_BTB   : update direction counter / write branch_target
//   actual_taken        : resolved direction
//   branch_target       : resolved target
//   branch_count        : number of wen_BHT updates, saturating at 16'hFFFF
//   mispredict_count    : wen_BHT updates that mispredicted, saturating
// ----------------------------------------------------------------------------
module dynamic_branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = 3,
    parameter int TAG_W       = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] PC_curr,
    input  logic [15:0] IF_ID_PC_curr,
    input  logic        IF_ID_prediction,
    input  logic        wen_BHT,
    input  logic        wen_BTB,
    input  logic        actual_taken,
    input  logic [15:0] branch_target,
    output logic        prediction,
    output logic [15:0] predicted_target,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic [TAG_W-1:0] rtag;
    logic [TAG_W-1:0] wtag;
    bp_entry_t        rd_entry;
    bp_entry_t        wr_old;
    bp_entry_t        wr_new;
    logic             hit;
    logic             whit;
    logic             tbl_we;

    logic [15:0] branch_count_d;
    logic [15:0] branch_count_q;
    logic [15:0] mispredict_count_d;
    logic [15:0] mispredict_count_q;

    assign ridx = PC_curr[IDX_W:1];
    assign rtag = PC_curr[15:IDX_W+1];
    assign widx = IF_ID_PC_curr[IDX_W:1];
    assign wtag = IF_ID_PC_curr[15:IDX_W+1];

    predictor_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (ridx),
        .rd_data (rd_entry),
        .wr_idx  (widx),
        .wr_old  (wr_old),
        .wr_en   (tbl_we),
        .wr_data (wr_new)
    );

    // Lookup. The table is already cleared while rst is high; the explicit
    // rst term keeps the outputs quiet even in the reset-edge delta.
    always_comb begin
        hit              = rd_entry.valid && (rd_entry.tag == TAG_MAX_W'(rtag));
        prediction       = !rst && hit && rd_entry.ctr[1];
        predicted_target = (!rst && hit) ? rd_entry.target : 16'h0000;
    end

    // Update / allocate. A tag miss on either write enable replaces the
    // direct-mapped entry outright; the old branch is simply lost.
    always_comb begin
        whit   = wr_old.valid && (wr_old.tag == TAG_MAX_W'(wtag));
        tbl_we = wen_BHT || wen_BTB;
        wr_new = wr_old;
        if (whit) begin
            if (wen_BHT) begin
                wr_new.ctr = sat_update(wr_old.ctr, actual_taken);
            end
            if (wen_BTB) begin
                wr_new.target = branch_target;
            end
        end else begin
            wr_new.valid  = 1'b1;
            wr_new.tag    = TAG_MAX_W'(wtag);
            wr_new.ctr    = actual_taken ? WEAK_T : WEAK_NT;
            wr_new.target = wen_BTB ? branch_target : 16'h0000;
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (wen_BHT) begin
            if (branch_count_q != CNT_MAX) begin
                branch_count_d = branch_count_q + 16'd1;
            end
            if ((actual_taken != IF_ID_prediction) && (mispredict_count_q != CNT_MAX)) begin
                mispredict_count_d = mispredict_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_q     <= 16'h0000;
            mispredict_count_q <= 16'h0000;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_dynamic_branch_predictor
// Directed bench for dynamic_branch_predictor. Each step pushes the expected
// outputs onto a scoreboard queue when its stimulus is driven; the entry is
// popped and compared against the DUT away from the rising edge.
// ----------------------------------------------------------------------------
module tb_dynamic_branch_predictor;

    logic        clk;
    logic        rst;
    logic [15:0] PC_curr;
    logic [15:0] IF_ID_PC_curr;
    logic        IF_ID_prediction;
    logic        wen_BHT;
    logic        wen_BTB;
    logic        actual_taken;
    logic [15:0] branch_target;
    logic        prediction;
    logic [15:0] predicted_target;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        pred;
        logic [15:0] tgt;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb[$];

    dynamic_branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .PC_curr          (PC_curr),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .IF_ID_prediction (IF_ID_prediction),
        .wen_BHT          (wen_BHT),
        .wen_BTB          (wen_BTB),
        .actual_taken     (actual_taken),
        .branch_target    (branch_target),
        .prediction       (prediction),
        .predicted_target (predicted_target),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string name, input logic pred, input logic [15:0] tgt,
                        input logic [15:0] bc, input logic [15:0] mc);
        exp_t e;
        e.name = name;
        e.pred = pred;
        e.tgt  = tgt;
        e.bc   = bc;
        e.mc   = mc;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (prediction === e.pred) else begin
            errors++;
            $error("FAIL %s.prediction: observed %b expected %b", e.name, prediction, e.pred);
        end
        checks++;
        assert (predicted_target === e.tgt) else begin
            errors++;
            $error("FAIL %s.predicted_target: observed %h expected %h", e.name, predicted_target, e.tgt);
        end
        checks++;
        assert (branch_count === e.bc) else begin
            errors++;
            $error("FAIL %s.branch_count: observed %h expected %h", e.name, branch_count, e.bc);
        end
        checks++;
        assert (mispredict_count === e.mc) else begin
            errors++;
            $error("FAIL %s.mispredict_count: observed %h expected %h", e.name, mispredict_count, e.mc);
        end
    endtask

    task automatic drive_wr(input logic [15:0] pc, input logic bht, input logic btb,
                            input logic taken, input logic pred, input logic [15:0] tgt);
        IF_ID_PC_curr    = pc;
        wen_BHT          = bht;
        wen_BTB          = btb;
        actual_taken     = taken;
        IF_ID_prediction = pred;
        branch_target    = tgt;
    endtask

    task automatic idle();
        wen_BHT = 1'b0;
        wen_BTB = 1'b0;
    endtask

    // Advance past the next rising edge; inputs change at edge + 1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Write one update, let it land, then compare on the falling edge.
    task automatic upd_and_check(input string name, input logic [15:0] pc, input logic bht,
                                 input logic btb, input logic taken, input logic pred,
                                 input logic [15:0] tgt, input logic e_pred,
                                 input logic [15:0] e_tgt, input logic [15:0] e_bc,
                                 input logic [15:0] e_mc);
        drive_wr(pc, bht, btb, taken, pred, tgt);
        push(name, e_pred, e_tgt, e_bc, e_mc);
        cyc();
        idle();
        @(negedge clk);
        check();
    endtask

    initial begin
        rst              = 1'b1;
        PC_curr          = 16'h0004;
        IF_ID_PC_curr    = 16'h0000;
        IF_ID_prediction = 1'b0;
        wen_BHT          = 1'b0;
        wen_BTB          = 1'b0;
        actual_taken     = 1'b0;
        branch_target    = 16'h0000;

        // Reset held and released
        #2;
        push("rst_hold", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        check();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push("post_rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        check();

        // Train 0x0010; lookup in the write cycle still sees the empty entry
        cyc();
        PC_curr = 16'h0010;
        drive_wr(16'h0010, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0040);
        push("train_read_old", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        check();
        push("trained", 1'b1, 16'h0040, 16'h0001, 16'h0001);
        cyc();
        idle();
        @(negedge clk);
        check();

        // Saturation: 10 -> 11 -> 11 -> 11, then 10, then 01
        cyc();
        upd_and_check("sat_t0", 16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0040, 16'd2, 16'd1);
        upd_and_check("sat_t1", 16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0040, 16'd3, 16'd1);
        upd_and_check("sat_t2", 16'h0010, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0040, 16'd4, 16'd1);
        upd_and_check("sat_nt1", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0040, 16'd5, 16'd2);
        upd_and_check("sat_nt2", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0040, 16'd6, 16'd3);

        // Target-only write on a hit leaves the weak-not-taken counter alone
        upd_and_check("btb_only", 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0080, 1'b0, 16'h0080, 16'd6, 16'd3);

        // Allocation on a fresh index without a target, then strengthen it
        PC_curr = 16'h0004;
        upd_and_check("alloc_nt", 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd7, 16'd3);
        upd_and_check("alloc_t", 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0000, 16'd8, 16'd3);
        PC_curr = 16'h0010;
        push("other_idx", 1'b0, 16'h0080, 16'd8, 16'd3);
        #1;
        check();

        // Read-old on a hit entry whose counter is about to cross to taken
        cyc();
        drive_wr(16'h0010, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        push("read_old_hit", 1'b0, 16'h0080, 16'd8, 16'd3);
        @(negedge clk);
        check();
        push("retrain", 1'b1, 16'h0080, 16'd9, 16'd4);
        cyc();
        idle();
        @(negedge clk);
        check();

        // Alias 0x0110 shares index 0 with 0x0010 and evicts it
        upd_and_check("alias_old", 16'h0110, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd10, 16'd4);
        PC_curr = 16'h0004;
        push("alias_keep", 1'b1, 16'h0000, 16'd10, 16'd4);
        #1;
        check();

        // Reset asserted mid-cycle while an update is pending
        cyc();
        drive_wr(16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        #2;
        rst = 1'b1;
        push("rst_async", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        #1;
        check();
        cyc();
        idle();
        rst = 1'b0;
        push("rst_drop", 1'b0, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        check();

        // First update after release applies normally
        cyc();
        PC_curr = 16'h0010;
        upd_and_check("post_rst_upd", 16'h0010, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0123, 1'b1, 16'h0123, 16'd1, 16'd0);

        // Drive both statistics counters past 16'hFFFF (index 1, away from 0x0010)
        cyc();
        drive_wr(16'h0022, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        push("stat_sat", 1'b1, 16'h0123, 16'hFFFF, 16'hFFFF);
        repeat (65540) cyc();
        idle();
        @(negedge clk);
        check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
